// File: rtl/cpu_out_ctrl_pkg.sv
// Shared types and constants for the CPU run sequencer and output buffer.
package cpu_out_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    RESET_CPU = 3'd1,
    RUN       = 3'd2,
    DRAIN     = 3'd3,
    DONE      = 3'd4
  } state_t;

  // Entries kept free when the CPU is stalled, absorbing words already in flight.
  localparam int SKID = 2;

endpackage

// File: rtl/cpu_out_ctrl_out_fifo.sv
// Show-ahead FIFO for captured CPU output words; accepts a push while full
// when a pop happens in the same cycle.
module out_fifo #(
  parameter int DATAWIDTH = 25,
  parameter int DEPTH     = 8,
  localparam int AW       = $clog2(DEPTH)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 i_push,
  input  logic [DATAWIDTH-1:0] i_data,
  input  logic                 i_pop,
  output logic [DATAWIDTH-1:0] o_data,
  output logic                 o_full,
  output logic                 o_empty,
  output logic [AW:0]          o_count
);

  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [DATAWIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]        r_wrPtr;
  logic [AW-1:0]        r_rdPtr;
  logic [AW:0]          r_count;
  logic                 w_push;
  logic                 w_pop;

  assign o_full  = (r_count == FULL_CNT);
  assign o_empty = (r_count == '0);
  assign w_pop   = i_pop && !o_empty;
  assign w_push  = i_push && (!o_full || w_pop);
  assign o_data  = r_mem[r_rdPtr];
  assign o_count = r_count;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wrPtr <= r_wrPtr + 1'b1;
      if (w_pop)  r_rdPtr <= r_rdPtr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage carries no reset; validity is tracked by r_count alone.
  always_ff @(posedge clock) begin
    if (w_push) r_mem[r_wrPtr] <= i_data;
  end

endmodule

// File: rtl/cpu_out_ctrl.sv
// CPU run sequencer: pulses CPU reset, runs until target words are captured, buffers them.
// Optional idle timeout in RUN is built when OUTCTRL_TIMEOUT_EN is defined (adds timedOut).
module cpu_out_ctrl
  import cpu_out_ctrl_pkg::*;
#(
  parameter int DATAWIDTH  = 25,
  parameter int DEPTH      = 8,
  parameter int COUNTWIDTH = 16,
  parameter int RSTCYCLES  = 2,
  parameter int TIMEOUT    = 1024
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [COUNTWIDTH-1:0] target,
  output logic                  cpuReset,
  output logic                  cpuStall,
  input  logic                  outFlag,
  input  logic [DATAWIDTH-1:0]  out,
  output logic [DATAWIDTH-1:0]  wordData,
  output logic                  wordValid,
  input  logic                  wordReady,
  output logic [COUNTWIDTH-1:0] wordCount,
  output logic                  busy,
  output logic                  done,
`ifdef OUTCTRL_TIMEOUT_EN
  output logic                  timedOut,
`endif
  output logic                  overflow
);

  localparam int AW      = $clog2(DEPTH);
  localparam int RW      = (RSTCYCLES > 1) ? $clog2(RSTCYCLES) : 1;
  localparam int STALL_I = DEPTH - SKID;
  localparam int RLAST_I = RSTCYCLES - 1;
  localparam logic [AW:0]   STALL_LVL = STALL_I[AW:0];
  localparam logic [RW-1:0] RST_LAST  = RLAST_I[RW-1:0];

  state_t                r_state;
  state_t                w_nextState;
  logic [RW-1:0]         r_rstCnt;
  logic [COUNTWIDTH-1:0] r_target;
  logic [COUNTWIDTH-1:0] r_captured;
  logic [COUNTWIDTH-1:0] r_wordCount;
  logic                  r_overflow;

  logic                  w_startOk;
  logic                  w_strobe;
  logic                  w_pop;
  logic                  w_pushOk;
  logic                  w_lastWord;
  logic                  w_timeoutHit;
  logic [DATAWIDTH-1:0]  w_head;
  logic                  w_fifoFull;
  logic                  w_fifoEmpty;
  logic [AW:0]           w_fifoCount;

  out_fifo #(
    .DATAWIDTH (DATAWIDTH),
    .DEPTH     (DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .i_push  (w_pushOk),
    .i_data  (out),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_fifoFull),
    .o_empty (w_fifoEmpty),
    .o_count (w_fifoCount)
  );

  assign w_startOk  = start && ((r_state == IDLE) || (r_state == DONE));
  assign w_strobe   = (r_state == RUN) && outFlag;
  assign w_pop      = !w_fifoEmpty && wordReady;
  assign w_pushOk   = w_strobe && (!w_fifoFull || w_pop);
  assign w_lastWord = w_pushOk && ((r_captured + 1'b1) == r_target);

  assign wordValid = !w_fifoEmpty;
  assign wordData  = w_fifoEmpty ? '0 : w_head;
  assign wordCount = r_wordCount;
  assign overflow  = r_overflow;
  assign busy      = (r_state == RESET_CPU) || (r_state == RUN) || (r_state == DRAIN);
  assign done      = (r_state == DONE);

`ifdef OUTCTRL_TIMEOUT_EN
  localparam int TW      = $clog2(TIMEOUT + 1);
  localparam int TLAST_I = TIMEOUT - 1;
  localparam logic [TW-1:0] IDLE_LAST = TLAST_I[TW-1:0];

  logic [TW-1:0] r_idleCnt;
  logic          r_timedOut;

  assign w_timeoutHit = (r_state == RUN) && !outFlag && (r_idleCnt == IDLE_LAST);
  assign timedOut     = r_timedOut;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_idleCnt  <= '0;
      r_timedOut <= 1'b0;
    end else begin
      if (w_startOk)         r_timedOut <= 1'b0;
      else if (w_timeoutHit) r_timedOut <= 1'b1;
      if ((r_state != RUN) || outFlag) r_idleCnt <= '0;
      else                             r_idleCnt <= r_idleCnt + 1'b1;
    end
  end
`else
  // Without the idle counter RUN never times out; TIMEOUT is then inert.
  assign w_timeoutHit = (TIMEOUT < 0);
`endif

  always_comb begin
    w_nextState = r_state;
    cpuReset    = 1'b0;
    cpuStall    = 1'b1;
    case (r_state)
      IDLE, DONE: begin
        cpuReset = (r_state == IDLE);
        if (w_startOk) w_nextState = (target == '0) ? DONE : RESET_CPU;
      end
      RESET_CPU: begin
        cpuReset = 1'b1;
        if (r_rstCnt == RST_LAST) w_nextState = RUN;
      end
      RUN: begin
        cpuStall = (w_fifoCount >= STALL_LVL);
        if (w_lastWord || w_timeoutHit) w_nextState = DRAIN;
      end
      DRAIN: begin
        if (w_fifoEmpty) w_nextState = DONE;
      end
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= IDLE;
      r_rstCnt    <= '0;
      r_captured  <= '0;
      r_wordCount <= '0;
      r_overflow  <= 1'b0;
    end else begin
      r_state  <= w_nextState;
      r_rstCnt <= ((r_state == RESET_CPU) && (w_nextState == RESET_CPU)) ? r_rstCnt + 1'b1 : '0;
      if (w_startOk) begin
        r_captured  <= '0;
        r_wordCount <= '0;
        r_overflow  <= 1'b0;
      end else begin
        if (w_pushOk)              r_captured  <= r_captured + 1'b1;
        if (w_pop)                 r_wordCount <= r_wordCount + 1'b1;
        if (w_strobe && !w_pushOk) r_overflow  <= 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (w_startOk) r_target <= target;
  end

endmodule

// File: tb/tb_cpu_out_ctrl.sv
// Randomized bench for cpu_out_ctrl against a queue-based model of the run/capture rules.
module tb_cpu_out_ctrl;

  localparam int DW    = 25;
  localparam int DEPTH = 8;
  localparam int CW    = 16;
  localparam int RSTC  = 2;

  localparam int M_IDLE  = 0;
  localparam int M_RST   = 1;
  localparam int M_RUN   = 2;
  localparam int M_DRAIN = 3;
  localparam int M_DONE  = 4;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [CW-1:0] target = '0;
  logic          outFlag = 1'b0;
  logic [DW-1:0] out = '0;
  logic          wordReady = 1'b0;
  logic          cpuReset, cpuStall, wordValid, busy, done, overflow;
  logic [DW-1:0] wordData;
  logic [CW-1:0] wordCount;
`ifdef OUTCTRL_TIMEOUT_EN
  logic          timedOut;
`endif

  cpu_out_ctrl #(
    .DATAWIDTH (DW),
    .DEPTH     (DEPTH),
    .COUNTWIDTH(CW),
    .RSTCYCLES (RSTC),
    .TIMEOUT   (1024)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .target    (target),
    .cpuReset  (cpuReset),
    .cpuStall  (cpuStall),
    .outFlag   (outFlag),
    .out       (out),
    .wordData  (wordData),
    .wordValid (wordValid),
    .wordReady (wordReady),
    .wordCount (wordCount),
    .busy      (busy),
    .done      (done),
`ifdef OUTCTRL_TIMEOUT_EN
    .timedOut  (timedOut),
`endif
    .overflow  (overflow)
  );

  always #5 clock = ~clock;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: phase, word queue, and the run's counters.
  int            m_ph = M_IDLE;
  int            m_rleft, m_wc, m_cap, m_tgt, m_sz;
  bit            m_ovf, m_pop, m_push, m_strobe;
  bit            m_ok = 1'b0;
  logic [DW-1:0] q[$];

  always @(posedge clock) begin
    if (reset) begin
      m_ph = M_IDLE; q.delete(); m_wc = 0; m_cap = 0; m_ovf = 0; m_tgt = 0; m_rleft = 0;
      m_ok = 1'b1;
    end else if (m_ok) begin
      m_sz     = q.size();
      m_pop    = (m_sz > 0) && wordReady;
      m_strobe = (m_ph == M_RUN) && outFlag;
      m_push   = m_strobe && ((m_sz < DEPTH) || m_pop);
      if (m_pop) begin void'(q.pop_front()); m_wc++; end
      if (m_push) begin q.push_back(out); m_cap++; end
      if (m_strobe && !m_push) m_ovf = 1'b1;
      case (m_ph)
        M_IDLE, M_DONE:
          if (start) begin
            m_tgt = int'(target); m_cap = 0; m_wc = 0; m_ovf = 1'b0; m_rleft = RSTC;
            m_ph = (target == 0) ? M_DONE : M_RST;
          end
        M_RST: begin
          m_rleft--;
          if (m_rleft == 0) m_ph = M_RUN;
        end
        M_RUN:   if (m_push && (m_cap == m_tgt)) m_ph = M_DRAIN;
        M_DRAIN: if (m_sz == 0) m_ph = M_DONE;
        default: ;
      endcase
    end
  end

  logic [DW-1:0] e_data;
  always @(negedge clock) begin
    if (m_ok) begin
      e_data = (q.size() > 0) ? q[0] : '0;
      chk("cpuReset",  cpuReset,  (m_ph == M_IDLE) || (m_ph == M_RST));
      chk("cpuStall",  cpuStall,  (m_ph != M_RUN) || (q.size() >= DEPTH - 2));
      chk("wordValid", wordValid, q.size() > 0);
      chk("wordData",  wordData,  e_data);
      chk("wordCount", wordCount, m_wc);
      chk("busy",      busy,      (m_ph == M_RST) || (m_ph == M_RUN) || (m_ph == M_DRAIN));
      chk("done",      done,      m_ph == M_DONE);
      chk("overflow",  overflow,  m_ovf);
    end
  end

  logic [DW-1:0] popped[$];

  task automatic tick();
    if (wordValid && wordReady) popped.push_back(wordData);
    @(negedge clock);
    #1;
  endtask

  task automatic wait_run(input string nm);
    int c = 0;
    while (!(busy && !cpuReset) && c < 50) begin tick(); c++; end
    chk(nm, busy && !cpuReset, 1);
  endtask

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation did not finish, got running, expected finished");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int rc, k, cyc;
    logic [31:0] rnd;

    // Reset held for three cycles.
    reset = 1'b1;
    repeat (3) tick();
    chk("t1_cpuReset",  cpuReset,  1);
    chk("t1_cpuStall",  cpuStall,  1);
    chk("t1_wordValid", wordValid, 0);
    chk("t1_done",      done,      0);
    chk("t1_overflow",  overflow,  0);
    reset = 1'b0;
    tick();

    // Five words, consumer always ready.
    wordReady = 1'b1; popped.delete();
    start = 1'b1; target = 5; tick(); start = 1'b0;
    rc = 0; k = 1; cyc = 0;
    while (!done && cyc < 200) begin
      if (busy && cpuReset) rc++;
      if (busy && !cpuReset && !cpuStall && k <= 5) begin outFlag = 1'b1; out = DW'(k); k++; end
      else outFlag = 1'b0;
      tick(); cyc++;
    end
    outFlag = 1'b0;
    chk("t2_done",      done,          1);
    chk("t2_rstcycles", rc,            2);
    chk("t2_wordCount", wordCount,     5);
    chk("t2_overflow",  overflow,      0);
    chk("t2_npopped",   popped.size(), 5);
    for (int i = 0; i < 5; i++)
      if (i < popped.size()) chk("t2_word", popped[i], i + 1);

    // Fill with consumer stalled; push+pop at full; then a dropped strobe.
    wordReady = 1'b0;
    start = 1'b1; target = 20; tick(); start = 1'b0;
    wait_run("t3_run_reached");
    for (int j = 1; j <= 10; j++) begin
      outFlag = 1'b1; out = DW'(j); wordReady = (j == 9);
      tick();
      if (j == 5) chk("t3_stall_at5", cpuStall, 0);
      if (j == 6) chk("t3_stall_at6", cpuStall, 1);
      if (j == 8) begin chk("t3_ovf_full", overflow, 0); chk("t3_head_full", wordData, 1); end
      if (j == 9) begin
        chk("t4_ovf_pushpop", overflow, 0);
        chk("t4_head_after",  wordData, 2);
        chk("t4_still_full",  cpuStall, 1);
      end
      if (j == 10) chk("t3_ovf_drop", overflow, 1);
    end
    wordReady = 1'b1; k = 11; cyc = 0;
    while (!done && cyc < 300) begin
      outFlag = 1'b1; out = DW'(k); k++;
      tick(); cyc++;
    end
    outFlag = 1'b0;
    chk("t3_done",       done,      1);
    chk("t3_wordCount",  wordCount, 20);
    chk("t3_ovf_sticky", overflow,  1);

    // target == 0 from IDLE.
    reset = 1'b1; tick(); reset = 1'b0;
    start = 1'b1; target = 0; tick(); start = 1'b0;
    chk("t5_done",  done,      1);
    chk("t5_valid", wordValid, 0);
    chk("t5_busy",  busy,      0);

    // Reset in RUN with three words buffered.
    wordReady = 1'b0;
    start = 1'b1; target = 10; tick(); start = 1'b0;
    wait_run("t6_run_reached");
    for (int j = 0; j < 3; j++) begin
      rnd = $urandom(); outFlag = 1'b1; out = rnd[DW-1:0]; tick();
    end
    outFlag = 1'b0;
    chk("t6_valid_before", wordValid, 1);
    reset = 1'b1; tick(); reset = 1'b0;
    chk("t6_valid",     wordValid, 0);
    chk("t6_wordCount", wordCount, 0);
    chk("t6_cpuReset",  cpuReset,  1);
    chk("t6_busy",      busy,      0);

    // Randomized runs, checked cycle by cycle against the model.
    for (int r = 0; r < 40; r++) begin
      int pf, rp, abort_at;
      bit ign, do_abort;
      pf       = $urandom_range(1, 4);
      rp       = $urandom_range(1, 4);
      ign      = ($urandom_range(0, 3) == 0);
      do_abort = ($urandom_range(0, 7) == 0);
      abort_at = $urandom_range(3, 40);
      start = 1'b1; target = CW'($urandom_range(0, 24)); tick(); start = 1'b0;
      cyc = 0;
      while (!done && cyc < 1500) begin
        rnd       = $urandom();
        out       = rnd[DW-1:0];
        outFlag   = ($urandom_range(0, 3) < pf) && (ign || !cpuStall);
        wordReady = ($urandom_range(0, 3) < rp);
        start     = ($urandom_range(0, 15) == 0);
        target    = CW'($urandom_range(0, 24));
        reset     = do_abort && (cyc == abort_at);
        tick(); cyc++;
      end
      reset = 1'b0; start = 1'b0; outFlag = 1'b0;
      chk("rand_run_done", done, 1);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
